// File: rtl/cpu_datapath_if.sv
// Control-word, program-load and observation signals between the decoder side and cpu_datapath.
interface cpu_datapath_if;
  logic       hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j;
  logic       prog_mode, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] insn, out_val, bus;
  logic       out_valid, bus_err, halted, cf, zf;

  modport master (
    output hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j,
    output prog_mode, prog_we, prog_addr, prog_data,
    input  insn, out_val, bus, out_valid, bus_err, halted, cf, zf
  );

  modport slave (
    input  hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j,
    input  prog_mode, prog_we, prog_addr, prog_data,
    output insn, out_val, bus, out_valid, bus_err, halted, cf, zf
  );
endinterface

// File: rtl/cpu_datapath.sv
// 8-bit CPU register/bus datapath with a 16x8 RAM and program-load port.
// Optional carry/zero flags and conditional jumps are enabled by defining CPU_FLAGS_EN.
module cpu_datapath (
  input  logic          clk,
  input  logic          rst,
  cpu_datapath_if.slave dp
);
  logic [7:0] ram [16];
  logic [3:0] pc, mar;
  logic [7:0] ir, a_reg, b_reg, out_reg, bus_val, alu_sum;
  logic       out_pulse, halt_reg, cf_reg, zf_reg, take_jump, run;
  logic [2:0] driver_count;

  // Fixed-priority bus mux; lower-priority drivers are masked on a conflict.
  always_comb begin
    bus_val = 8'h00;
    if (dp.ro)        bus_val = ram[mar];
    else if (dp.io)   bus_val = {4'h0, ir[3:0]};
    else if (dp.ao)   bus_val = a_reg;
    else if (dp.sumo) bus_val = alu_sum;
    else if (dp.co)   bus_val = {4'h0, pc};
  end

  assign driver_count = {2'b00, dp.ro} + {2'b00, dp.io} + {2'b00, dp.ao}
                      + {2'b00, dp.sumo} + {2'b00, dp.co};
  assign run = !dp.prog_mode && !dp.hlt;

`ifdef CPU_FLAGS_EN
  logic alu_carry;
  assign {alu_carry, alu_sum} = {1'b0, a_reg} + {1'b0, dp.sub ? ~b_reg : b_reg} + {8'h00, dp.sub};

  // Opcodes 7 and 8 are the conditional jumps (carry / zero); all others jump unconditionally.
  always_comb begin
    take_jump = dp.j;
    if (ir[7:4] == 4'h7)      take_jump = dp.j && cf_reg;
    else if (ir[7:4] == 4'h8) take_jump = dp.j && zf_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cf_reg <= 1'b0;
      zf_reg <= 1'b0;
    end else if (run && dp.ai && dp.sumo) begin
      cf_reg <= alu_carry;
      zf_reg <= (alu_sum == 8'h00);
    end
  end
`else
  assign alu_sum   = a_reg + (dp.sub ? ~b_reg : b_reg) + {7'h00, dp.sub};
  assign take_jump = dp.j;
  assign cf_reg    = 1'b0;
  assign zf_reg    = 1'b0;
`endif

  // All loads sample the pre-edge bus; a halt freezes every register except halted itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= 4'h0;
      mar       <= 4'h0;
      ir        <= 8'h00;
      a_reg     <= 8'h00;
      b_reg     <= 8'h00;
      out_reg   <= 8'h00;
      out_pulse <= 1'b0;
      halt_reg  <= 1'b0;
    end else begin
      out_pulse <= 1'b0;
      if (!dp.prog_mode) begin
        halt_reg <= dp.hlt;
        if (!dp.hlt) begin
          if (dp.mi) mar   <= bus_val[3:0];
          if (dp.ii) ir    <= bus_val;
          if (dp.ai) a_reg <= bus_val;
          if (dp.bi) b_reg <= bus_val;
          if (take_jump)  pc <= bus_val[3:0];
          else if (dp.ce) pc <= pc + 4'd1;
          if (dp.oi) begin
            out_reg   <= bus_val;
            out_pulse <= 1'b1;
          end
        end
      end
    end
  end

  // RAM has no reset so a loaded program survives it; reset still blocks any write that edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (dp.prog_mode) begin
        if (dp.prog_we) ram[dp.prog_addr] <= dp.prog_data;
      end else if (!dp.hlt && dp.ri) begin
        ram[mar] <= bus_val;
      end
    end
  end

  assign dp.insn      = ir;
  assign dp.out_val   = out_reg;
  assign dp.out_valid = out_pulse;
  assign dp.bus       = bus_val;
  assign dp.bus_err   = (driver_count > 3'd1);
  assign dp.halted    = halt_reg;
  assign dp.cf        = cf_reg;
  assign dp.zf        = zf_reg;
endmodule

// File: tb/tb_cpu_datapath.sv
// Randomized and directed bench for cpu_datapath with an abstract reference model
// and an out_valid scoreboard; control words are 15-bit masks in decoder order.
module tb_cpu_datapath;
  localparam logic [14:0] C_J    = 15'h0001, C_CO  = 15'h0002, C_CE = 15'h0004,
                          C_OI   = 15'h0008, C_BI  = 15'h0010, C_SUB = 15'h0020,
                          C_SUMO = 15'h0040, C_AO  = 15'h0080, C_AI = 15'h0100,
                          C_II   = 15'h0200, C_IO  = 15'h0400, C_RO = 15'h0800,
                          C_RI   = 15'h1000, C_MI  = 15'h2000, C_HLT = 15'h4000;
  localparam logic [14:0] DRIVERS = C_RO | C_IO | C_AO | C_SUMO | C_CO;

  logic clk = 1'b0;
  logic rst;
  cpu_datapath_if dp();
  cpu_datapath dut (.clk(clk), .rst(rst), .dp(dp));
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_ram [16];
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_ir, m_a, m_b, m_out;
  logic       m_halted, m_cf, m_zf;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  logic [7:0] seen_bus;
  logic       seen_err;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic has(input logic [14:0] c, input logic [14:0] m);
    return |(c & m);
  endfunction

  function automatic logic [7:0] model_bus(input logic [14:0] c);
    if (has(c, C_RO))   return m_ram[m_mar];
    if (has(c, C_IO))   return {4'h0, m_ir[3:0]};
    if (has(c, C_AO))   return m_a;
    if (has(c, C_SUMO)) return has(c, C_SUB) ? m_a - m_b : m_a + m_b;
    if (has(c, C_CO))   return {4'h0, m_pc};
    return 8'h00;
  endfunction

  function automatic logic model_err(input logic [14:0] c);
    return $countones(c & DRIVERS) > 1;
  endfunction

  // Reference behaviour: compute everything from the pre-edge state, then commit.
  task automatic model_step(input logic [14:0] c, input logic pm, input logic pwe,
                            input logic [3:0] pa, input logic [7:0] pd, input logic r);
    logic [7:0] b;
    int sum;
    logic take;
    b = model_bus(c);
    if (r) begin
      m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
      m_halted = 0; m_cf = 0; m_zf = 0;
    end else if (pm) begin
      if (pwe) m_ram[pa] = pd;
    end else begin
      m_halted = has(c, C_HLT);
      if (!has(c, C_HLT)) begin
        sum  = has(c, C_SUB) ? int'(m_a) - int'(m_b) : int'(m_a) + int'(m_b);
        take = has(c, C_J);
`ifdef CPU_FLAGS_EN
        if (m_ir[7:4] == 4'h7 && !m_cf) take = 1'b0;
        if (m_ir[7:4] == 4'h8 && !m_zf) take = 1'b0;
        if (has(c, C_AI) && has(c, C_SUMO)) begin
          m_cf = has(c, C_SUB) ? (sum >= 0) : (sum > 255);
          m_zf = (sum == 0) || (sum == 256);
        end
`endif
        if (has(c, C_RI)) m_ram[m_mar] = b;
        if (take) m_pc = b[3:0];
        else if (has(c, C_CE)) m_pc = m_pc + 4'd1;
        if (has(c, C_MI)) m_mar = b[3:0];
        if (has(c, C_II)) m_ir = b;
        if (has(c, C_AI)) m_a = b;
        if (has(c, C_BI)) m_b = b;
        if (has(c, C_OI)) begin
          m_out = b;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic check_output();
    check8("insn", dp.insn, m_ir);
    check8("out_val", dp.out_val, m_out);
    check8("halted", {7'h00, dp.halted}, {7'h00, m_halted});
    check8("cf", {7'h00, dp.cf}, {7'h00, m_cf});
    check8("zf", {7'h00, dp.zf}, {7'h00, m_zf});
  endtask

  task automatic apply_stimulus(input logic [14:0] c, input logic pm, input logic pwe,
                                input logic [3:0] pa, input logic [7:0] pd, input logic r);
    @(negedge clk);
    check_output();
    {dp.hlt, dp.mi, dp.ri, dp.ro, dp.io, dp.ii, dp.ai, dp.ao, dp.sumo, dp.sub,
     dp.bi, dp.oi, dp.ce, dp.co, dp.j} = c;
    dp.prog_mode = pm;
    dp.prog_we   = pwe;
    dp.prog_addr = pa;
    dp.prog_data = pd;
    rst          = r;
    #1;
    seen_bus = dp.bus;
    seen_err = dp.bus_err;
    check8("bus", seen_bus, model_bus(c));
    check8("bus_err", {7'h00, seen_err}, {7'h00, model_err(c)});
    @(posedge clk);
    model_step(c, pm, pwe, pa, pd, r);
  endtask

  task automatic ctl(input logic [14:0] c);
    apply_stimulus(c, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
    apply_stimulus(15'h0, 1'b1, 1'b1, a, d, 1'b0);
  endtask

  task automatic reset_cycle(input logic [14:0] c);
    apply_stimulus(c, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
  endtask

  task automatic fetch();
    ctl(C_CO | C_MI);
    ctl(C_RO | C_II | C_CE);
  endtask

  // Scoreboard: every expected output pushed at an edge must appear as a pulse at the next negedge.
  always @(negedge clk) begin
    if (dp.out_valid === 1'b1 || exp_q.size() != 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL out_valid: got unexpected pulse val %h, expected no pulse", dp.out_val);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dp.out_valid !== 1'b1 || dp.out_val !== mon_exp) begin
          errors++;
          $display("[TB] FAIL out_pulse: got valid %b val %h, expected valid 1 val %h",
                   dp.out_valid, dp.out_val, mon_exp);
        end
      end
    end
  end

  initial begin
    logic [7:0]  word;
    logic [14:0] c;
    rst = 1'b1;
    {dp.hlt, dp.mi, dp.ri, dp.ro, dp.io, dp.ii, dp.ai, dp.ao, dp.sumo, dp.sub,
     dp.bi, dp.oi, dp.ce, dp.co, dp.j} = 15'h0;
    dp.prog_mode = 1'b0; dp.prog_we = 1'b0; dp.prog_addr = 4'h0; dp.prog_data = 8'h00;
    m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
    m_halted = 0; m_cf = 0; m_zf = 0;
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;

    reset_cycle(15'h0);
    reset_cycle(15'h0);

    for (int i = 0; i < 16; i++) begin
      word = 8'($urandom);
      case (i)
        0: word = 8'h1E;  1: word = 8'h2F;  2: word = 8'hE0;
        3: word = 8'hF0; 14: word = 8'h1C; 15: word = 8'h0E;
        default: ;
      endcase
      prog_write(4'(i), word);
    end
    reset_cycle(15'h0);

    // LDA 14; ADD 15; OUT; HLT
    fetch(); ctl(C_IO | C_MI); ctl(C_RO | C_AI);
    fetch(); ctl(C_IO | C_MI); ctl(C_RO | C_BI); ctl(C_AI | C_SUMO);
    fetch(); ctl(C_AO | C_OI);
    fetch(); ctl(C_HLT);
    #1;
    check8("program out_val", dp.out_val, 8'h2A);
    check8("program halted", {7'h00, dp.halted}, 8'h01);
    ctl(C_HLT | C_CE | C_CO);
    check8("halt pc", seen_bus, 8'h04);
    ctl(C_HLT | C_CO);
    check8("halt pc frozen", seen_bus, 8'h04);

    // Subtract wrap and flags
    prog_write(4'd10, 8'h05);
    prog_write(4'd11, 8'h07);
    reset_cycle(15'h0);
    for (int i = 0; i < 10; i++) ctl(C_CE);
    ctl(C_CO | C_MI); ctl(C_RO | C_AI); ctl(C_CE);
    ctl(C_CO | C_MI); ctl(C_RO | C_BI);
    ctl(C_AI | C_SUMO | C_SUB);
    #1;
`ifdef CPU_FLAGS_EN
    check8("sub wrap cf", {7'h00, dp.cf}, 8'h00);
    check8("sub wrap zf", {7'h00, dp.zf}, 8'h00);
`endif
    ctl(C_AO);
    check8("sub wrap A", seen_bus, 8'hFE);
    ctl(C_RO | C_AI);
    ctl(C_AI | C_SUMO | C_SUB);
    #1;
`ifdef CPU_FLAGS_EN
    check8("sub zero cf", {7'h00, dp.cf}, 8'h01);
    check8("sub zero zf", {7'h00, dp.zf}, 8'h01);
`endif
    ctl(C_AO);
    check8("sub zero A", seen_bus, 8'h00);

    // PC wrap and jump priority over increment
    for (int i = 0; i < 4; i++) ctl(C_CE);
    ctl(C_CE | C_CO);
    check8("pc at 15", seen_bus, 8'h0F);
    ctl(C_CO);
    check8("pc wrap", seen_bus, 8'h00);
    prog_write(4'd11, 8'h09);
    ctl(C_RO | C_CE | C_J);
    ctl(C_CO);
    check8("jump over ce", seen_bus, 8'h09);

    // Bus conflict
    prog_write(4'd11, 8'h03);
    ctl(C_RO | C_J);
    prog_write(4'd11, 8'h55);
    ctl(C_RO | C_AI);
    ctl(C_AO | C_CO);
    check8("conflict bus", seen_bus, 8'h55);
    check8("conflict err", {7'h00, seen_err}, 8'h01);
    ctl(15'h0);
    check8("idle bus", seen_bus, 8'h00);
    check8("idle err", {7'h00, seen_err}, 8'h00);

    // Program-mode isolation
    apply_stimulus(C_AI | C_CE | C_RI | C_AO, 1'b1, 1'b1, 4'd6, 8'hAB, 1'b0);
    ctl(C_AO);
    check8("iso A", seen_bus, 8'h55);
    ctl(C_CO);
    check8("iso pc", seen_bus, 8'h03);
    ctl(C_RO);
    check8("iso ram[mar]", seen_bus, 8'h55);
    prog_write(4'd11, 8'h06);
    ctl(C_RO | C_MI);
    ctl(C_RO);
    check8("iso ram[6]", seen_bus, 8'hAB);

    // Reset during oi
    ctl(C_AO | C_OI);
    reset_cycle(C_AO | C_OI);
    #1;
    check8("rst out_val", dp.out_val, 8'h00);
    check8("rst out_valid", {7'h00, dp.out_valid}, 8'h00);
    ctl(C_CO);
    check8("rst pc", seen_bus, 8'h00);
    ctl(C_RO);
    check8("rst ram intact", seen_bus, 8'h1E);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      c = 15'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        c = c & ~DRIVERS;
        case ($urandom_range(0, 5))
          0: c = c | C_RO;   1: c = c | C_IO;   2: c = c | C_AO;
          3: c = c | C_SUMO; 4: c = c | C_CO;   default: ;
        endcase
      end
      if ($urandom_range(0, 7) != 0) c = c & ~C_HLT;
      apply_stimulus(c, $urandom_range(0, 11) == 0, 1'($urandom), 4'($urandom),
                     8'($urandom), $urandom_range(0, 39) == 0);
    end
    ctl(15'h0);
    ctl(15'h0);
    @(negedge clk);
    #1;
    check8("scoreboard drained", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
